mem_arbiter4: RTL and testbench

MEM_ARBITER4 -- requirements
Module: mem_arbiter4

---
 rtl/mem_arbiter4.sv | 102 ++++++++++
 tb/tb_mem_arbiter4.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter4.sv
// Four-requester round-robin arbiter for a shared 32-bit memory resource.
// One-cycle grant latency, no pre-emption, forced release after TIMEOUT hold cycles.
module mem_arbiter4 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mem_ready,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [3:0] grant_n;
  logic [1:0] sel_n, last, last_n, win, idx;
  logic [7:0] cnt, cnt_n;
  logic       timeout_n, found;

  // Rotating-priority search starting just after the last granted index.
  always_comb begin
    win   = last;
    idx   = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    sel_n     = sel;
    cnt_n     = cnt;
    last_n    = last;
    timeout_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_n = GRANT;
          grant_n = 4'(1) << win;
          sel_n   = win;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        cnt_n = cnt + 8'd1;
        // Completion wins over both the hold limit and a dropped request.
        if (mem_ready) begin
          state_n = RELEASE;
          grant_n = '0;
        end else if (cnt == HOLD_MAX) begin
          state_n   = RELEASE;
          grant_n   = '0;
          timeout_n = 1'b1;
        end else if (!req[sel]) begin
          state_n = RELEASE;
          grant_n = '0;
        end
      end
      RELEASE: begin
        state_n = IDLE;
        last_n  = sel;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      sel     <= '0;
      cnt     <= '0;
      last    <= 2'd3;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      sel     <= sel_n;
      cnt     <= cnt_n;
      last    <= last_n;
      timeout <= timeout_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter4.sv
// Directed and randomized checks for mem_arbiter4 with a short hold limit.
module tb_mem_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       mem_ready;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter4 #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mem_ready (mem_ready),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic t);
    chk({tag, ".grant"},   8'(grant),   8'(g));
    chk({tag, ".sel"},     8'(sel),     8'(s));
    chk({tag, ".busy"},    8'(busy),    8'(b));
    chk({tag, ".timeout"}, 8'(timeout), 8'(t));
  endtask

  // Enter GRANT for index w, complete with mem_ready, then sit one IDLE cycle.
  task automatic grant_complete(input string tag, input logic [1:0] w);
    step();
    chk_out({tag, ".grant"}, 4'(1) << w, w, 1'b1, 1'b0);
    mem_ready = 1'b1;
    step();
    chk_out({tag, ".release"}, 4'b0000, w, 1'b1, 1'b0);
    mem_ready = 1'b0;
    step();
    chk_out({tag, ".idle"}, 4'b0000, w, 1'b0, 1'b0);
  endtask

  logic [3:0] req_s, prev_grant;
  int         waits [4];
  bit         starting;

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    mem_ready = 1'b0;
    #2;
    chk_out("reset_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_out("reset_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk_out("idle_no_req", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Full rotation from reset priority.
    req = 4'b1111;
    grant_complete("rr0", 2'd0);
    grant_complete("rr1", 2'd1);
    grant_complete("rr2", 2'd2);
    grant_complete("rr3", 2'd3);
    grant_complete("rr0b", 2'd0);

    // Wrap: last=2 with req 0101 skips 3 and picks 0, then 2.
    req = 4'b0100;
    grant_complete("to2", 2'd2);
    req = 4'b0101;
    grant_complete("wrap0", 2'd0);
    grant_complete("wrap2", 2'd2);

    // Hold limit of 4 cycles, then forced release and re-grant.
    req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("hold%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    step();
    chk_out("to_release", 4'b0000, 2'd1, 1'b1, 1'b1);
    step();
    chk_out("to_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
    step();
    chk_out("to_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
    mem_ready = 1'b1;
    step();
    chk_out("to_regrant_rel", 4'b0000, 2'd1, 1'b1, 1'b0);
    mem_ready = 1'b0;
    step();

    // Abort by request drop, then drop together with completion.
    req = 4'b0001;
    step();
    chk_out("abort_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk_out("abort_rel", 4'b0000, 2'd0, 1'b1, 1'b0);
    step();
    chk_out("abort_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0001;
    step();
    chk_out("drop_rdy_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    mem_ready = 1'b1;
    step();
    chk_out("drop_rdy_rel", 4'b0000, 2'd0, 1'b1, 1'b0);
    step();
    chk_out("rdy_in_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    mem_ready = 1'b0;

    // Completion on the final hold cycle is not a timeout.
    req = 4'b0100;
    for (int i = 0; i < 4; i++) step();
    chk_out("edge_hold3", 4'b0100, 2'd2, 1'b1, 1'b0);
    mem_ready = 1'b1;
    step();
    chk_out("edge_done", 4'b0000, 2'd2, 1'b1, 1'b0);
    mem_ready = 1'b0;
    req = 4'b0000;
    step();

    // Reset mid-grant drops everything at once.
    req = 4'b1000;
    step();
    chk_out("pre_rst_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    step();
    chk_out("post_rst_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    mem_ready = 1'b1;
    step();
    chk_out("post_rst_rel", 4'b0000, 2'd3, 1'b1, 1'b0);
    mem_ready = 1'b0;
    req = 4'b0000;
    step();

    // Randomized traffic with structural and fairness checks.
    for (int i = 0; i < 4; i++) waits[i] = 0;
    prev_grant = grant;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      mem_ready = ($urandom_range(0, 4) == 0);
      req_s = req;
      step();
      chk("rnd.onehot0", 8'($onehot0(grant)), 8'd1);
      if (grant != 4'b0000) begin
        chk("rnd.sel_match", 8'(grant), 8'(4'(1) << sel));
        chk("rnd.busy", 8'(busy), 8'd1);
      end
      if (timeout) chk("rnd.to_nogrant", 8'(grant), 8'd0);
      starting = (prev_grant == 4'b0000) && (grant != 4'b0000);
      if (starting) begin
        for (int i = 0; i < 4; i++) begin
          if (grant[i]) waits[i] = 0;
          else if (req_s[i]) waits[i]++;
          else waits[i] = 0;
          chk($sformatf("rnd.starve%0d", i), 8'(waits[i] <= 3), 8'd1);
        end
      end
      prev_grant = grant;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
